// File: rtl/up_down_counter.sv
// Free-running modulo-2^WIDTH up/down counter with asynchronous active-high reset.
// Wraps silently at both ends. The output is the count register itself,
// so there is no combinational path from up to out.
`timescale 1ns/1ps

module up_down_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] count_next;

    // Next count: one step in the direction selected by up; the carry/borrow is dropped.
    always_comb begin
        count_next = out;
        if (up) begin
            count_next = out + WIDTH'(1);
        end else begin
            count_next = out - WIDTH'(1);
        end
    end

    // Count register; reset clears it immediately and overrides counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= count_next;
        end
    end

endmodule

// File: tb/tb_up_down_counter.sv
// Directed self-checking bench for up_down_counter (WIDTH=3).
`timescale 1ns/1ps

module tb_up_down_counter;

    localparam int unsigned WIDTH = 3;

    logic             clk;
    logic             reset;
    logic             up;
    logic [WIDTH-1:0] out;

    int checks = 0;
    int errors = 0;

    up_down_counter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .up    (up),
        .out   (out)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time bound so the run always ends.
    initial begin
        #5000;
        $display("FAIL timeout: got no finish, expected finish before 5000 ns");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Wait for the next rising edge and check the count just after it.
    task automatic tick(input string tag, input logic [WIDTH-1:0] exp);
        @(posedge clk);
        #1;
        check(tag, out, exp);
    endtask

    initial begin
        logic [WIDTH-1:0] held;

        // 1. Reset asserted from t=0 with up=1.
        reset = 1'b1;
        up    = 1'b1;
        tick("reset_edge", 3'd0);

        // 2. Release at 10 ns, count up 1..7.
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick($sformatf("count_up_%0d", i), 3'(i));
        end

        // 3. Direction change at 80 ns, count down 6..0 with no idle cycle.
        @(negedge clk);
        up = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            tick($sformatf("count_down_%0d", i), 3'(i));
        end

        // 5. Reset at 150 ns, then up=1 at 170 ns while reset stays high.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_async_zero", out, 3'd0);
        tick("reset_hold_dn_a", 3'd0);
        tick("reset_hold_dn_b", 3'd0);
        @(negedge clk);
        up = 1'b1;
        tick("reset_hold_up_a", 3'd0);
        tick("reset_hold_up_b", 3'd0);
        @(negedge clk);
        up = 1'bx;
        tick("reset_hold_upx", 3'd0);

        // 6. Release, toggle up every cycle starting with up=1.
        @(negedge clk);
        reset = 1'b0;
        up    = 1'b1;
        tick("toggle_1", 3'd1);
        @(negedge clk); up = 1'b0;
        tick("toggle_0", 3'd0);
        @(negedge clk); up = 1'b1;
        tick("toggle_1b", 3'd1);
        @(negedge clk); up = 1'b0;
        tick("toggle_0b", 3'd0);

        // 4. Wrap at both ends: 0 down -> 7, then 7 up -> 0.
        tick("wrap_down", 3'd7);
        @(negedge clk); up = 1'b1;
        tick("wrap_up", 3'd0);

        // up changes between edges must not reach out.
        tick("pre_comb_1", 3'd1);
        #2;
        held = out;
        up = 1'b0;
        #1;
        check("no_comb_path", out, 3'd1);
        up = 1'b1;
        tick("post_comb_2", 3'd2);
        tick("pre_async_3", 3'd3);

        // Reset asserted mid-cycle clears out before the next edge.
        #2;
        reset = 1'b1;
        #1;
        check("async_mid_cycle", out, 3'd0);
        @(negedge clk);
        reset = 1'b0;
        tick("resume_from_zero", 3'd1);
        tick("resume_2", 3'd2);
        if (held !== 3'd1) begin
            check("held_sample", held, 3'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
